// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the RISC control path: phase encoding, opcodes and
// the opcode-class encoding latched by the instruction sequencer.
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        PhFetch  = 3'd0,
        PhDecode = 3'd1,
        PhExec   = 3'd2,
        PhMem    = 3'd3,
        PhWb     = 3'd4,
        PhTrap   = 3'd5
    } phase_e;

    typedef enum logic [2:0] {
        ClsOther   = 3'd0,
        ClsLoad    = 3'd1,
        ClsStore   = 3'd2,
        ClsMul     = 3'd3,
        ClsDiv     = 3'd4,
        ClsIllegal = 3'd5
    } op_cls_e;

    localparam logic [5:0] OP_LD   = 6'h18;
    localparam logic [5:0] OP_ST   = 6'h19;
    localparam logic [5:0] OP_JMP  = 6'h1B;
    localparam logic [5:0] OP_BEQ  = 6'h1D;
    localparam logic [5:0] OP_BNE  = 6'h1E;
    localparam logic [5:0] OP_LDR  = 6'h1F;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_MUL  = 6'h22;
    localparam logic [5:0] OP_DIV  = 6'h23;
    localparam logic [5:0] OP_MULC = 6'h32;
    localparam logic [5:0] OP_DIVC = 6'h33;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_mul;
        logic is_div;
    } op_info_t;

    // Collapse classifier flags into the single class the sequencer stores.
    function automatic op_cls_e op_class(op_info_t info);
        if (!info.legal)        return ClsIllegal;
        else if (info.is_load)  return ClsLoad;
        else if (info.is_store) return ClsStore;
        else if (info.is_mul)   return ClsMul;
        else if (info.is_div)   return ClsDiv;
        else                    return ClsOther;
    endfunction

endpackage

// File: rtl/instr_seq_fsm_if.sv
// Sequencer <-> core handshake bundle: opcode/acks in, phase strobes and
// retired count out, plus a debug preload for the retired counter.
interface instr_seq_fsm_if;
    logic [5:0]  opcode;
    logic        imem_ack;
    logic        dmem_ack;
    logic        ret_load;
    logic [31:0] ret_value;

    logic        imem_req;
    logic        dmem_req;
    logic        ir_en;
    logic        pc_en;
    logic        werf_en;
    logic        wr_en;
    logic        trap;
    logic [2:0]  phase;
    logic [31:0] retired;

    modport master (
        input  opcode, imem_ack, dmem_ack, ret_load, ret_value,
        output imem_req, dmem_req, ir_en, pc_en, werf_en, wr_en, trap, phase, retired
    );

    modport slave (
        output opcode, imem_ack, dmem_ack, ret_load, ret_value,
        input  imem_req, dmem_req, ir_en, pc_en, werf_en, wr_en, trap, phase, retired
    );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode decoder: legality plus load/store/mul/div flags.
// Also used by the control ROM consistency checks.
module opcode_classifier
    import risc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_info_t   info
);

    always_comb begin
        info = '0;
        case (opcode)
            OP_LD, OP_LDR: begin
                info.legal   = 1'b1;
                info.is_load = 1'b1;
            end
            OP_ST: begin
                info.legal    = 1'b1;
                info.is_store = 1'b1;
            end
            OP_JMP, OP_BEQ, OP_BNE: info.legal = 1'b1;
            OP_MUL, OP_MULC: begin
                info.legal  = 1'b1;
                info.is_mul = 1'b1;
            end
            OP_DIV, OP_DIVC: begin
                info.legal  = 1'b1;
                info.is_div = 1'b1;
            end
            // ALU blocks 0x20-0x2F / 0x30-0x3F: holes at x7, xB and xF.
            default: info.legal = opcode[5] && (opcode[2:0] != 3'b111) &&
                                  (opcode[3:0] != 4'hB);
        endcase
    end

endmodule

// File: rtl/instr_seq_fsm.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP phases,
// memory handshakes, multi-cycle MUL/DIV hold and phase-gated write strobes.
module instr_seq_fsm
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    instr_seq_fsm_if.master   bus
);

    localparam logic [15:0] MulLat = 16'(MUL_CYCLES);
    localparam logic [15:0] DivLat = 16'(DIV_CYCLES);

    phase_e      state_q, state_d;
    op_cls_e     cls_q, cls_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] retired_q, retired_d;
    op_info_t    info;

    logic imem_req, dmem_req, ir_en, pc_en, werf_en, wr_en, trap;

    opcode_classifier u_classifier (
        .opcode (bus.opcode),
        .info   (info)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PhFetch;
            cls_q     <= ClsOther;
            cnt_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cnt_d    = cnt_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        werf_en  = 1'b0;
        wr_en    = 1'b0;
        trap     = 1'b0;
        case (state_q)
            PhFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_en   = 1'b1;
                    state_d = PhDecode;
                end
            end
            PhDecode: begin
                cls_d = op_class(info);
                case (cls_d)
                    ClsMul:  cnt_d = MulLat;
                    ClsDiv:  cnt_d = DivLat;
                    default: cnt_d = 16'd1;
                endcase
                state_d = (cls_d == ClsIllegal) ? PhTrap : PhExec;
            end
            PhExec: begin
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    state_d = (cls_q == ClsLoad || cls_q == ClsStore) ? PhMem : PhWb;
                end
            end
            PhMem: begin
                dmem_req = 1'b1;
                wr_en    = (cls_q == ClsStore);
                if (bus.dmem_ack) begin
                    if (cls_q == ClsStore) begin
                        pc_en   = 1'b1;
                        state_d = PhFetch;
                    end else begin
                        state_d = PhWb;
                    end
                end
            end
            PhWb: begin
                werf_en = 1'b1;
                pc_en   = 1'b1;
                state_d = PhFetch;
            end
            PhTrap: begin
                // XP save: the trap reuses the register-file write port.
                trap    = 1'b1;
                pc_en   = 1'b1;
                werf_en = 1'b1;
                state_d = PhFetch;
            end
            default: state_d = PhFetch;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (bus.ret_load) begin
            retired_d = bus.ret_value;
        end else if (pc_en) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Gate with reset so a mid-instruction reset kills strobes immediately.
    assign bus.imem_req = imem_req & ~rst;
    assign bus.dmem_req = dmem_req & ~rst;
    assign bus.ir_en    = ir_en    & ~rst;
    assign bus.pc_en    = pc_en    & ~rst;
    assign bus.werf_en  = werf_en  & ~rst;
    assign bus.wr_en    = wr_en    & ~rst;
    assign bus.trap     = trap     & ~rst;
    assign bus.phase    = rst ? 3'd0 : state_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_instr_seq_fsm.sv
// Directed bench for instr_seq_fsm: per-cycle expected phases/strobes queued
// from an independent opcode model, then popped and compared every cycle.
module tb_instr_seq_fsm;

    localparam int unsigned MulN = 4;
    localparam int unsigned DivN = 16;

    typedef struct packed {
        logic [5:0] op;
        logic       iack;
        logic       dack;
        logic [2:0] phase;
        logic [6:0] flags;  // {imem_req, dmem_req, ir_en, pc_en, werf_en, wr_en, trap}
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [31:0] exp_ret = '0;
    step_t sb[$];

    instr_seq_fsm_if bus ();

    instr_seq_fsm #(
        .MUL_CYCLES (MulN),
        .DIV_CYCLES (DivN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {bus.phase, bus.imem_req, bus.dmem_req, bus.ir_en, bus.pc_en,
                bus.werf_en, bus.wr_en, bus.trap};
    endfunction

    task automatic check10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got phase/strobes=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic check_ret(input string tag);
        n_checks++;
        assert (bus.retired === exp_ret) else begin
            n_fails++;
            $error("FAIL %s retired: got=%h required=%h", tag, bus.retired, exp_ret);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic iack, input logic dack,
                        input logic [2:0] ph, input logic [6:0] flags);
        step_t s;
        s.op = op; s.iack = iack; s.dack = dack; s.phase = ph; s.flags = flags;
        sb.push_back(s);
    endtask

    // Instruction model: iw/dw are wait cycles before each ack; noise drives
    // stray acks and a junk opcode wherever they must be ignored.
    task automatic run_instr(input string tag, input logic [5:0] op, input int iw,
                             input int dw, input bit noise, input int abort_k);
        logic [5:0] junk;
        bit legal, is_ld, is_st;
        int exec_n;
        step_t s;
        junk   = noise ? 6'h27 : op;
        legal  = op inside {6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F,
                            [6'h20:6'h26], [6'h28:6'h2A], [6'h2C:6'h2E],
                            [6'h30:6'h36], [6'h38:6'h3A], [6'h3C:6'h3E]};
        is_ld  = (op == 6'h18) || (op == 6'h1F);
        is_st  = (op == 6'h19);
        exec_n = (op == 6'h22 || op == 6'h32) ? MulN :
                 (op == 6'h23 || op == 6'h33) ? DivN : 1;

        for (int i = 0; i < iw; i++) push(junk, 1'b0, noise, 3'd0, 7'b1000000);
        push(junk, 1'b1, noise, 3'd0, 7'b1010000);
        push(op, noise, noise, 3'd1, 7'b0000000);
        if (!legal) begin
            push(junk, noise, noise, 3'd5, 7'b0001101);
        end else begin
            for (int i = 0; i < exec_n; i++) push(junk, noise, noise, 3'd2, 7'b0000000);
            if (is_ld || is_st) begin
                for (int i = 0; i < dw; i++)
                    push(junk, noise, 1'b0, 3'd3, is_st ? 7'b0100010 : 7'b0100000);
                push(junk, noise, 1'b1, 3'd3, is_st ? 7'b0101010 : 7'b0100000);
            end
            if (!is_st) push(junk, noise, noise, 3'd4, 7'b0001100);
        end

        for (int k = 0; sb.size() > 0; k++) begin
            s = sb.pop_front();
            @(negedge clk);
            bus.opcode   = s.op;
            bus.imem_ack = s.iack;
            bus.dmem_ack = s.dack;
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check10({tag, " reset-abort"}, observed(), 10'b0);
                exp_ret = '0;
                check_ret({tag, " reset-abort"});
                sb.delete();
                @(posedge clk);
                @(negedge clk);
                bus.imem_ack = 1'b0;
                bus.dmem_ack = 1'b0;
                rst = 1'b0;
                #1;
                check10({tag, " restart"}, observed(), 10'b000_1000000);
                return;
            end
            #1;
            check10($sformatf("%s cyc%0d", tag, k), observed(), {s.phase, s.flags});
            check_ret($sformatf("%s cyc%0d", tag, k));
            if (s.flags[3]) exp_ret++;
        end
    endtask

    task automatic idle_check_ret(input string tag);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        check_ret(tag);
    endtask

    initial begin
        bus.opcode    = '0;
        bus.imem_ack  = 1'b1;
        bus.dmem_ack  = 1'b1;
        bus.ret_load  = 1'b0;
        bus.ret_value = '0;

        // Reset state, with acks asserted to show Mealy strobes are gated.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check10("reset", observed(), 10'b0);
        check_ret("reset");
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check10("post-reset fetch", observed(), 10'b000_1000000);

        run_instr("add",      6'h20, 0, 0, 1'b0, -1);
        run_instr("ld_wait2", 6'h18, 0, 2, 1'b0, -1);
        run_instr("st",       6'h19, 0, 1, 1'b0, -1);
        run_instr("div",      6'h23, 0, 0, 1'b0, -1);
        run_instr("mulc_iw2", 6'h32, 2, 0, 1'b0, -1);
        run_instr("ill_00",   6'h00, 0, 0, 1'b0, -1);
        run_instr("ill_27",   6'h27, 1, 0, 1'b0, -1);
        run_instr("jmp_noise", 6'h1B, 1, 0, 1'b1, -1);
        run_instr("ldr_noise", 6'h1F, 0, 1, 1'b1, -1);
        run_instr("st_noise",  6'h19, 0, 2, 1'b1, -1);
        run_instr("srac",     6'h3E, 0, 0, 1'b0, -1);
        run_instr("ill_2b",   6'h2B, 0, 0, 1'b1, -1);
        run_instr("ill_3f",   6'h3F, 0, 0, 1'b0, -1);
        idle_check_ret("before abort");

        // Store aborted by reset while waiting in MEM.
        run_instr("st_abort", 6'h19, 0, 5, 1'b0, 4);
        run_instr("add_after_rst", 6'h20, 0, 0, 1'b0, -1);
        idle_check_ret("after abort");

        // Retired counter wrap.
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.ret_load  = 1'b1;
        bus.ret_value = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.ret_load  = 1'b0;
        exp_ret       = 32'hFFFF_FFFF;
        run_instr("wrap_add", 6'h20, 0, 0, 1'b0, -1);
        idle_check_ret("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
